mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares data-memory port A (byte-write BRAM, 1-cycle synchronous read) between two requesters: the pipeline Memory stage (core) and the boot/debug program loader.
- Sits between the memory stage and the BRAM. Sequences boot-time exclusive loader access, then run-time priority arbitration with starvation protection.
- Routes registered read data back to the owning requester and generates a Memory-stage stall.

Parameters:
ADDR_WIDTH, 10, BRAM word-address width; depth = 2**ADDR_WIDTH words
MAX_WAIT, 4, consecutive cycles a loader request may lose before it is forced a grant (1..15)

Ports:
CLK  in  1  clock
RST  in  1  asynchronous active-high reset
Boot_Done  in  1  level; loader has finished image load, enables core access
Core_Req  in  1  core access request (held until granted)
Core_W_En  in  1  1 = store, 0 = load
Core_Byte_En  in  4  byte lanes for store
Core_Addr  in  32  byte address
Core_W_Data  in  32  store data
Core_Gnt  out  1  core access accepted this cycle
Core_R_Valid  out  1  core load data valid on R_Data
Ldr_Req  in  1  loader request (held until granted)
Ldr_W_En  in  1  1 = write, 0 = read
Ldr_Addr  in  32  byte address (word aligned)
Ldr_W_Data  in  32  write data
Ldr_Gnt  out  1  loader access accepted this cycle
Ldr_R_Valid  out  1  loader read data valid on R_Data
R_Data  out  32  BRAM read data, passed through
Stall_Mem  out  1  Core_Req & ~Core_Gnt
Addr_Err  out  1  one-cycle pulse: granted access was out of range and was suppressed
RAM_En  out  1  port A enable
RAM_W_En  out  4  port A byte write enables
RAM_Addr  out  ADDR_WIDTH  port A word address
RAM_W_Data  out  32  port A write data
RAM_R_Data  in  32  port A read data (valid 1 cycle after a read is issued)

Behaviour:
- Reset (async, RST=1) state:
  - State = BOOT, starvation counter = 0, read-owner/pending registers = 0.
  - Core_R_Valid = Ldr_R_Valid = Addr_Err = 0.
  - Combinational outputs with no request active: RAM_En = 0, RAM_W_En = 0.
- FSM states: BOOT, RUN.
  - BOOT -> RUN when Boot_Done = 1 at a clock edge.
  - RUN -> BOOT only via RST; Boot_Done deassertion in RUN is ignored.
- BOOT:
  - Ldr_Gnt = Ldr_Req.
  - Core_Gnt = 0, so a core request stalls.
- RUN, grant rule (combinational, same cycle):
  - Only one requester: that one is granted.
  - Both requesting, counter < MAX_WAIT: core wins.
  - Both requesting, counter == MAX_WAIT: loader wins.
- Starvation counter (4 bits):
  - +1 on each edge with Ldr_Req & ~Ldr_Gnt in RUN.
  - Cleared on Ldr_Gnt or on Ldr_Req = 0.
  - Saturates at MAX_WAIT.
- Port drive for the granted requester:
  - RAM_En = 1.
  - RAM_Addr = Addr[ADDR_WIDTH+1:2].
  - RAM_W_Data = W_Data.
  - RAM_W_En = Core_Byte_En for core stores, 4'b1111 for loader writes, 0 for reads.
  - Ungranted cycle: RAM_En = 0, RAM_W_En = 0.
- Range check: a granted access with Addr[31:ADDR_WIDTH+2] != 0 gets RAM_En = 0 and RAM_W_En = 0, and Addr_Err pulses on the next cycle. The requester is still granted, so the pipeline does not hang. A read returns R_Valid with R_Data = 0.
- Read latency:
  - Granted read at cycle N: owner and pending are registered.
  - At N+1, the owner's R_Valid = 1 for exactly one cycle, with R_Data = RAM_R_Data.
  - R_Data = 0 whenever neither R_Valid is set.
- Back-to-back reads from either requester: one per cycle, no bubbles. Owner tags are pipelined, so interleaved core and loader reads are routed correctly.
- Writes produce no R_Valid. Write-then-read to the same address on consecutive cycles returns the new data (BRAM read-after-write on the following cycle).
- Boot_Done rising while a loader read is in flight: R_Valid still goes to the loader at N+1. A core request in that same N+1 cycle may be granted.
- RST mid-operation: the pending read is discarded and no R_Valid is produced after reset.

Decomposition:
- Shared definitions package gets:
  - arb_state_t enum {ARB_BOOT, ARB_RUN}
  - owner_t enum {OWN_CORE, OWN_LDR}
  - MAX_WAIT default as a localparam constant
- One natural sub-module: arb_starve_counter (saturating wait counter with clear), reusable by later arbiters.

Test Plan:
- Boot exclusivity: RST then Ldr write 0x00000010 <- 0xDEADBEEF while Core_Req = 1 -> Ldr_Gnt = 1, Core_Gnt = 0, Stall_Mem = 1, RAM_Addr = 4, RAM_W_En = 4'hF.
- Transition: Boot_Done = 1, then core load 0x10 -> Core_Gnt in the same cycle, Core_R_Valid next cycle with R_Data = 0xDEADBEEF, Ldr_R_Valid = 0.
- Starvation: in RUN, Core_Req and Ldr_Req held high continuously -> core granted 4 cycles, loader granted on the 5th, core granted again on the 6th; pattern repeats.
- Byte store: core store Byte_En = 4'b0100, addr 0x12, data 0x00AB0000 over 0xDEADBEEF -> read of 0x10 returns 0xDEABBEEF.
- Out-of-range: core load addr 0x00001000 (ADDR_WIDTH = 10) -> Core_Gnt = 1, RAM_En = 0, Addr_Err pulse and Core_R_Valid next cycle with R_Data = 0.
- Reset mid-read: core read granted, RST asserted before the next edge -> no Core_R_Valid, state BOOT, all registered outputs 0.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared types and constants for the data-memory port arbiter
package mem_port_arbiter_pkg;
  typedef enum logic {ARB_BOOT, ARB_RUN} arb_state_t;
  typedef enum logic {OWN_CORE, OWN_LDR} owner_t;
  localparam int MAX_WAIT_DEFAULT = 4;
  localparam int CNT_W = 4;
endpackage

// File: rtl/arb_starve_counter.sv
// arb_starve_counter: saturating wait counter with synchronous clear
module arb_starve_counter #(
  parameter int MAX = 4,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d = clr ? '0 : (inc && cnt_q != W'(MAX)) ? cnt_q + 1'b1 : cnt_q;
    cnt = cnt_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: boot-exclusive then starvation-protected core/loader sharing of a BRAM port
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  Boot_Done,
  input  logic                  Core_Req,
  input  logic                  Core_W_En,
  input  logic [3:0]            Core_Byte_En,
  input  logic [31:0]           Core_Addr,
  input  logic [31:0]           Core_W_Data,
  output logic                  Core_Gnt,
  output logic                  Core_R_Valid,
  input  logic                  Ldr_Req,
  input  logic                  Ldr_W_En,
  input  logic [31:0]           Ldr_Addr,
  input  logic [31:0]           Ldr_W_Data,
  output logic                  Ldr_Gnt,
  output logic                  Ldr_R_Valid,
  output logic [31:0]           R_Data,
  output logic                  Stall_Mem,
  output logic                  Addr_Err,
  output logic                  RAM_En,
  output logic [3:0]            RAM_W_En,
  output logic [ADDR_WIDTH-1:0] RAM_Addr,
  output logic [31:0]           RAM_W_Data,
  input  logic [31:0]           RAM_R_Data
);
  arb_state_t state_q, state_d;
  owner_t owner_q, owner_d;
  logic pend_q, pend_d, zero_q, zero_d, err_q, err_d;
  logic run, any_gnt, w_en, oor;
  logic [31:0] addr, word;
  logic [CNT_W-1:0] cnt;
  arb_starve_counter #(.MAX(MAX_WAIT), .W(CNT_W)) u_starve (
    .clk(CLK),
    .rst(RST),
    .inc(run & Ldr_Req & ~Ldr_Gnt),
    .clr(~Ldr_Req | Ldr_Gnt),
    .cnt(cnt)
  );
  always_comb begin
    run = state_q == ARB_RUN;
    Core_Gnt = run & Core_Req & (~Ldr_Req | (cnt != CNT_W'(MAX_WAIT)));
    Ldr_Gnt = Ldr_Req & (~run | ~Core_Req | (cnt == CNT_W'(MAX_WAIT)));
    any_gnt = Core_Gnt | Ldr_Gnt;
    addr = Ldr_Gnt ? Ldr_Addr : Core_Addr;
    w_en = Ldr_Gnt ? Ldr_W_En : Core_W_En;
    word = addr >> 2;
    oor = |(word >> ADDR_WIDTH);
    RAM_En = any_gnt & ~oor;
    RAM_W_En = (RAM_En & w_en) ? (Ldr_Gnt ? 4'hF : Core_Byte_En) : 4'h0;
    RAM_Addr = word[ADDR_WIDTH-1:0];
    RAM_W_Data = Ldr_Gnt ? Ldr_W_Data : Core_W_Data;
    Stall_Mem = Core_Req & ~Core_Gnt;
    state_d = (state_q == ARB_BOOT && Boot_Done) ? ARB_RUN : state_q;
    pend_d = any_gnt & ~w_en;
    owner_d = Ldr_Gnt ? OWN_LDR : OWN_CORE;
    zero_d = pend_d & oor;
    err_d = any_gnt & oor;
    Core_R_Valid = pend_q & (owner_q == OWN_CORE);
    Ldr_R_Valid = pend_q & (owner_q == OWN_LDR);
    Addr_Err = err_q;
    R_Data = (pend_q & ~zero_q) ? RAM_R_Data : '0;
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state_q <= ARB_BOOT;
      owner_q <= OWN_CORE;
      pend_q <= 1'b0;
      zero_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      pend_q <= pend_d;
      zero_q <= zero_d;
      err_q <= err_d;
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
  logic CLK, RST, Boot_Done;
  logic Core_Req, Core_W_En, Core_Gnt, Core_R_Valid;
  logic [3:0] Core_Byte_En;
  logic [31:0] Core_Addr, Core_W_Data;
  logic Ldr_Req, Ldr_W_En, Ldr_Gnt, Ldr_R_Valid;
  logic [31:0] Ldr_Addr, Ldr_W_Data;
  logic [31:0] R_Data, RAM_W_Data, RAM_R_Data;
  logic Stall_Mem, Addr_Err, RAM_En;
  logic [3:0] RAM_W_En;
  logic [9:0] RAM_Addr;
  logic [31:0] mem [0:1023];
  int errs = 0;
  int checks = 0;
  mem_port_arbiter #(.ADDR_WIDTH(10), .MAX_WAIT(4)) dut (
    .CLK(CLK), .RST(RST), .Boot_Done(Boot_Done),
    .Core_Req(Core_Req), .Core_W_En(Core_W_En), .Core_Byte_En(Core_Byte_En),
    .Core_Addr(Core_Addr), .Core_W_Data(Core_W_Data), .Core_Gnt(Core_Gnt),
    .Core_R_Valid(Core_R_Valid), .Ldr_Req(Ldr_Req), .Ldr_W_En(Ldr_W_En),
    .Ldr_Addr(Ldr_Addr), .Ldr_W_Data(Ldr_W_Data), .Ldr_Gnt(Ldr_Gnt),
    .Ldr_R_Valid(Ldr_R_Valid), .R_Data(R_Data), .Stall_Mem(Stall_Mem),
    .Addr_Err(Addr_Err), .RAM_En(RAM_En), .RAM_W_En(RAM_W_En),
    .RAM_Addr(RAM_Addr), .RAM_W_Data(RAM_W_Data), .RAM_R_Data(RAM_R_Data)
  );
  initial begin
    CLK = 0;
    forever #5 CLK = ~CLK;
  end
  always @(posedge CLK)
    if (RAM_En) begin
      for (int b = 0; b < 4; b++)
        if (RAM_W_En[b]) mem[RAM_Addr][8*b +: 8] <= RAM_W_Data[8*b +: 8];
      RAM_R_Data <= mem[RAM_Addr];
    end
  task automatic idle();
    Core_Req = 0; Core_W_En = 0; Core_Byte_En = 0; Core_Addr = 0; Core_W_Data = 0;
    Ldr_Req = 0; Ldr_W_En = 0; Ldr_Addr = 0; Ldr_W_Data = 0;
  endtask
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic test_reset();
    RST = 1; Boot_Done = 0; idle();
    repeat (2) @(posedge CLK);
    #1;
    checks++; if (Core_R_Valid !== 1'b0) begin errs++; $display("FAIL rst_core_rv got %b exp 0", Core_R_Valid); end
    checks++; if (Ldr_R_Valid !== 1'b0) begin errs++; $display("FAIL rst_ldr_rv got %b exp 0", Ldr_R_Valid); end
    checks++; if (Addr_Err !== 1'b0) begin errs++; $display("FAIL rst_addr_err got %b exp 0", Addr_Err); end
    checks++; if (RAM_En !== 1'b0) begin errs++; $display("FAIL rst_ram_en got %b exp 0", RAM_En); end
    checks++; if (RAM_W_En !== 4'h0) begin errs++; $display("FAIL rst_ram_w_en got %h exp 0", RAM_W_En); end
    checks++; if (R_Data !== 32'h0) begin errs++; $display("FAIL rst_r_data got %h exp 0", R_Data); end
    RST = 0;
    tick();
  endtask
  task automatic test_boot_exclusive();
    Core_Req = 1; Core_Addr = 32'h10;
    Ldr_Req = 1; Ldr_W_En = 1; Ldr_Addr = 32'h10; Ldr_W_Data = 32'hDEADBEEF;
    #1;
    checks++; if (Ldr_Gnt !== 1'b1) begin errs++; $display("FAIL boot_ldr_gnt got %b exp 1", Ldr_Gnt); end
    checks++; if (Core_Gnt !== 1'b0) begin errs++; $display("FAIL boot_core_gnt got %b exp 0", Core_Gnt); end
    checks++; if (Stall_Mem !== 1'b1) begin errs++; $display("FAIL boot_stall got %b exp 1", Stall_Mem); end
    checks++; if (RAM_Addr !== 10'd4) begin errs++; $display("FAIL boot_ram_addr got %0d exp 4", RAM_Addr); end
    checks++; if (RAM_W_En !== 4'hF) begin errs++; $display("FAIL boot_ram_w_en got %h exp f", RAM_W_En); end
    checks++; if (RAM_W_Data !== 32'hDEADBEEF) begin errs++; $display("FAIL boot_ram_w_data got %h exp deadbeef", RAM_W_Data); end
    tick();
    Ldr_Req = 0;
    #1;
    checks++; if (Core_Gnt !== 1'b0) begin errs++; $display("FAIL boot_core_alone got %b exp 0", Core_Gnt); end
    checks++; if (Ldr_R_Valid !== 1'b0) begin errs++; $display("FAIL boot_write_no_rv got %b exp 0", Ldr_R_Valid); end
    idle();
  endtask
  task automatic test_transition();
    Ldr_Req = 1; Ldr_W_En = 0; Ldr_Addr = 32'h10; Boot_Done = 1;
    #1;
    checks++; if (Ldr_Gnt !== 1'b1) begin errs++; $display("FAIL tr_ldr_gnt got %b exp 1", Ldr_Gnt); end
    tick();
    idle(); Boot_Done = 0;
    Core_Req = 1; Core_Addr = 32'h10;
    #1;
    checks++; if (Ldr_R_Valid !== 1'b1) begin errs++; $display("FAIL tr_ldr_rv got %b exp 1", Ldr_R_Valid); end
    checks++; if (R_Data !== 32'hDEADBEEF) begin errs++; $display("FAIL tr_ldr_data got %h exp deadbeef", R_Data); end
    checks++; if (Core_Gnt !== 1'b1) begin errs++; $display("FAIL tr_core_gnt got %b exp 1", Core_Gnt); end
    checks++; if (Stall_Mem !== 1'b0) begin errs++; $display("FAIL tr_stall got %b exp 0", Stall_Mem); end
    tick();
    idle();
    #1;
    checks++; if (Core_R_Valid !== 1'b1) begin errs++; $display("FAIL tr_core_rv got %b exp 1", Core_R_Valid); end
    checks++; if (R_Data !== 32'hDEADBEEF) begin errs++; $display("FAIL tr_core_data got %h exp deadbeef", R_Data); end
    checks++; if (Ldr_R_Valid !== 1'b0) begin errs++; $display("FAIL tr_ldr_rv_off got %b exp 0", Ldr_R_Valid); end
  endtask
  task automatic test_starvation();
    logic exp_l, prev_c, prev_l;
    prev_c = 0; prev_l = 0;
    Core_Req = 1; Core_Addr = 32'h10; Ldr_Req = 1; Ldr_Addr = 32'h10;
    for (int i = 0; i < 11; i++) begin
      #1;
      exp_l = (i % 5) == 4;
      checks++; if (Core_Gnt !== !exp_l) begin errs++; $display("FAIL starve_core_gnt[%0d] got %b exp %b", i, Core_Gnt, !exp_l); end
      checks++; if (Ldr_Gnt !== exp_l) begin errs++; $display("FAIL starve_ldr_gnt[%0d] got %b exp %b", i, Ldr_Gnt, exp_l); end
      if (i > 0) begin
        checks++; if (Core_R_Valid !== prev_c) begin errs++; $display("FAIL starve_core_rv[%0d] got %b exp %b", i, Core_R_Valid, prev_c); end
        checks++; if (Ldr_R_Valid !== prev_l) begin errs++; $display("FAIL starve_ldr_rv[%0d] got %b exp %b", i, Ldr_R_Valid, prev_l); end
        checks++; if (R_Data !== 32'hDEADBEEF) begin errs++; $display("FAIL starve_data[%0d] got %h exp deadbeef", i, R_Data); end
      end
      prev_c = !exp_l; prev_l = exp_l;
      tick();
    end
    idle();
    #1;
    checks++; if (Core_R_Valid !== 1'b1) begin errs++; $display("FAIL starve_last_rv got %b exp 1", Core_R_Valid); end
  endtask
  task automatic test_byte_store();
    Core_Req = 1; Core_W_En = 1; Core_Byte_En = 4'b0100; Core_Addr = 32'h12; Core_W_Data = 32'h00AB0000;
    #1;
    checks++; if (Core_Gnt !== 1'b1) begin errs++; $display("FAIL bs_gnt got %b exp 1", Core_Gnt); end
    checks++; if (RAM_W_En !== 4'b0100) begin errs++; $display("FAIL bs_w_en got %b exp 0100", RAM_W_En); end
    checks++; if (RAM_Addr !== 10'd4) begin errs++; $display("FAIL bs_addr got %0d exp 4", RAM_Addr); end
    tick();
    Core_W_En = 0; Core_Byte_En = 0; Core_Addr = 32'h10;
    #1;
    checks++; if (Core_R_Valid !== 1'b0) begin errs++; $display("FAIL bs_store_no_rv got %b exp 0", Core_R_Valid); end
    tick();
    idle();
    #1;
    checks++; if (Core_R_Valid !== 1'b1) begin errs++; $display("FAIL bs_rv got %b exp 1", Core_R_Valid); end
    checks++; if (R_Data !== 32'hDEABBEEF) begin errs++; $display("FAIL bs_data got %h exp deabbeef", R_Data); end
    tick();
  endtask
  task automatic test_back_to_back();
    Ldr_Req = 1; Ldr_W_En = 1; Ldr_Addr = 32'h20; Ldr_W_Data = 32'h12345678;
    #1;
    checks++; if (Ldr_Gnt !== 1'b1) begin errs++; $display("FAIL b2b_wr_gnt got %b exp 1", Ldr_Gnt); end
    tick();
    Ldr_W_En = 0;
    #1;
    checks++; if (Ldr_R_Valid !== 1'b0) begin errs++; $display("FAIL b2b_wr_no_rv got %b exp 0", Ldr_R_Valid); end
    tick();
    idle();
    Core_Req = 1; Core_Addr = 32'h20;
    #1;
    checks++; if (Ldr_R_Valid !== 1'b1) begin errs++; $display("FAIL b2b_ldr_rv got %b exp 1", Ldr_R_Valid); end
    checks++; if (R_Data !== 32'h12345678) begin errs++; $display("FAIL b2b_ldr_data got %h exp 12345678", R_Data); end
    tick();
    idle();
    #1;
    checks++; if (Core_R_Valid !== 1'b1) begin errs++; $display("FAIL b2b_core_rv got %b exp 1", Core_R_Valid); end
    checks++; if (Ldr_R_Valid !== 1'b0) begin errs++; $display("FAIL b2b_ldr_rv_off got %b exp 0", Ldr_R_Valid); end
    checks++; if (R_Data !== 32'h12345678) begin errs++; $display("FAIL b2b_core_data got %h exp 12345678", R_Data); end
    tick();
  endtask
  task automatic test_out_of_range();
    Core_Req = 1; Core_Addr = 32'h00001000;
    #1;
    checks++; if (Core_Gnt !== 1'b1) begin errs++; $display("FAIL oor_gnt got %b exp 1", Core_Gnt); end
    checks++; if (RAM_En !== 1'b0) begin errs++; $display("FAIL oor_ram_en got %b exp 0", RAM_En); end
    tick();
    idle();
    Ldr_Req = 1; Ldr_W_En = 1; Ldr_Addr = 32'hFFFF0000; Ldr_W_Data = 32'h55555555;
    #1;
    checks++; if (Addr_Err !== 1'b1) begin errs++; $display("FAIL oor_err got %b exp 1", Addr_Err); end
    checks++; if (Core_R_Valid !== 1'b1) begin errs++; $display("FAIL oor_rv got %b exp 1", Core_R_Valid); end
    checks++; if (R_Data !== 32'h0) begin errs++; $display("FAIL oor_data got %h exp 0", R_Data); end
    checks++; if (Ldr_Gnt !== 1'b1) begin errs++; $display("FAIL oor_ldr_gnt got %b exp 1", Ldr_Gnt); end
    checks++; if (RAM_W_En !== 4'h0) begin errs++; $display("FAIL oor_w_en got %h exp 0", RAM_W_En); end
    tick();
    idle();
    #1;
    checks++; if (Addr_Err !== 1'b1) begin errs++; $display("FAIL oor_ldr_err got %b exp 1", Addr_Err); end
    checks++; if (Ldr_R_Valid !== 1'b0) begin errs++; $display("FAIL oor_ldr_no_rv got %b exp 0", Ldr_R_Valid); end
    tick();
    checks++; if (Addr_Err !== 1'b0) begin errs++; $display("FAIL oor_err_pulse got %b exp 0", Addr_Err); end
  endtask
  task automatic test_reset_mid();
    Core_Req = 1; Core_Addr = 32'h10;
    #1;
    checks++; if (Core_Gnt !== 1'b1) begin errs++; $display("FAIL rm_gnt got %b exp 1", Core_Gnt); end
    #2;
    RST = 1;
    #1;
    checks++; if (Core_Gnt !== 1'b0) begin errs++; $display("FAIL rm_boot_gnt got %b exp 0", Core_Gnt); end
    checks++; if (Stall_Mem !== 1'b1) begin errs++; $display("FAIL rm_stall got %b exp 1", Stall_Mem); end
    tick();
    checks++; if (Core_R_Valid !== 1'b0) begin errs++; $display("FAIL rm_rv got %b exp 0", Core_R_Valid); end
    checks++; if (R_Data !== 32'h0) begin errs++; $display("FAIL rm_data got %h exp 0", R_Data); end
    checks++; if (Addr_Err !== 1'b0) begin errs++; $display("FAIL rm_err got %b exp 0", Addr_Err); end
    RST = 0;
    tick();
    checks++; if (Core_R_Valid !== 1'b0) begin errs++; $display("FAIL rm_rv_after got %b exp 0", Core_R_Valid); end
    checks++; if (Core_Gnt !== 1'b0) begin errs++; $display("FAIL rm_still_boot got %b exp 0", Core_Gnt); end
    idle();
  endtask
  initial begin
    test_reset();
    test_boot_exclusive();
    test_transition();
    test_starvation();
    test_byte_store();
    test_back_to_back();
    test_out_of_range();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
